// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
//   Shared types and constants for the Game-of-Life generation controller.
//
//   Contents:
//     GRID_W     - number of cells in the grid (8x8 = 64)
//     GRID_DIM   - grid edge length
//     GEN_CNT_W  - width of the committed-generation counter
//     PERIOD_W   - width of the WAIT-phase period counter (GEN_PERIOD <= 65535)
//     state_t    - controller state encoding (3-bit)
//     sat_inc()  - saturating increment for the generation counter
// ---------------------------------------------------------------------------
package life_pkg;

    localparam int GRID_DIM  = 8;
    localparam int GRID_W    = GRID_DIM * GRID_DIM;
    localparam int GEN_CNT_W = 16;
    localparam int PERIOD_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_REQ  = 3'd2,
        ST_BUSY = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    // Generation counter sticks at all-ones rather than wrapping to zero,
    // so a long-running board never appears freshly loaded.
    function automatic logic [GEN_CNT_W-1:0] sat_inc(input logic [GEN_CNT_W-1:0] v);
        return (v == '1) ? v : v + GEN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/life_period_counter.sv
// ---------------------------------------------------------------------------
// life_period_counter
//   Loadable down-counter that paces the WAIT phase between generations.
//   It stops at zero instead of wrapping, so a controller that lingers in
//   WAIT with the count already exhausted still sees zero asserted.
//
//   Ports:
//     clk         in   clock, rising edge
//     reset_n     in   asynchronous active-low reset (count -> 0)
//     load        in   load load_value this cycle (has priority over dec)
//     load_value  in   W  value to load
//     dec         in   decrement by one when non-zero
//     zero        out  count is zero
// ---------------------------------------------------------------------------
module life_period_counter
    import life_pkg::*;
#(
    parameter int W = PERIOD_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge, independent of
    // statement order or of other always_ff blocks reading it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/life_controller.sv
// ---------------------------------------------------------------------------
// life_controller
//   Sequencer for an 8x8 Game-of-Life engine. Holds the current grid, paces
//   generation requests to an external datapath, commits the evolved grid
//   when the datapath reports completion, and counts committed generations.
//
//   Build option:
//     LIFE_STABLE_DETECT_EN - when defined, a generation whose result equals
//                             the previous grid (still life) or is empty
//                             parks the controller in HALT and raises stable.
//                             When undefined there is no compare logic, HALT
//                             is unreachable and stable is tied low.
//
//   Parameters:
//     GEN_PERIOD  cycles spent in WAIT before each request (1..65535)
//
//   Ports:
//     clk        in   clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     on         in   level: free-run generations while high
//     step       in   pulse: single generation from IDLE/HALT while on=0
//     load       in   pulse: capture seed, clear gen_count, return to IDLE
//     seed       in   64  initial grid, bit row*8+col
//     dp_start   out  one-cycle request to evolve cur_grid
//     cur_grid   out  64  registered current grid (datapath operand)
//     dp_done    in   datapath result valid
//     dp_grid    in   64  evolved grid, sampled only with dp_done in BUSY
//     display    out  64  copy of cur_grid
//     gen_count  out  16  generations committed since load/reset
//     stable     out  controller is parked in HALT
//     busy       out  a generation is in flight (REQ or BUSY)
// ---------------------------------------------------------------------------
module life_controller
    import life_pkg::*;
#(
    parameter int GEN_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 on,
    input  logic                 step,
    input  logic                 load,
    input  logic [GRID_W-1:0]    seed,
    output logic                 dp_start,
    output logic [GRID_W-1:0]    cur_grid,
    input  logic                 dp_done,
    input  logic [GRID_W-1:0]    dp_grid,
    output logic [GRID_W-1:0]    display,
    output logic [GEN_CNT_W-1:0] gen_count,
    output logic                 stable,
    output logic                 busy
);

    // WAIT lasts GEN_PERIOD cycles: the counter is loaded with GEN_PERIOD-1
    // on entry and REQ follows the cycle in which it reads zero.
    localparam logic [PERIOD_W-1:0] PERIOD_M1 = PERIOD_W'(GEN_PERIOD - 1);

    state_t state;
    state_t state_nxt;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic stop_cond;
    logic commit;

    // -----------------------------------------------------------------------
    // Period counter
    // -----------------------------------------------------------------------
    assign cnt_dec = (state == ST_WAIT);

    life_period_counter #(
        .W (PERIOD_W)
    ) u_period (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (PERIOD_M1),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // -----------------------------------------------------------------------
    // Stop condition, judged against the grid the datapath was given.
    // -----------------------------------------------------------------------
`ifdef LIFE_STABLE_DETECT_EN
    assign stop_cond = (dp_grid == cur_grid) || (dp_grid == '0);
`else
    assign stop_cond = 1'b0;
`endif

    // A result is taken only in BUSY; a load in the same cycle wins, and any
    // dp_done seen in another state (late after load/reset) is dropped.
    assign commit = (state == ST_BUSY) && dp_done && !load;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state (also decides when the period counter reloads)
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path through the case leaves it unassigned and no latch is inferred.
        state_nxt = state;
        cnt_load  = 1'b0;

        if (load) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (on) begin
                        state_nxt = ST_WAIT;
                        cnt_load  = 1'b1;
                    end else if (step) begin
                        state_nxt = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // Dropping on abandons the wait even on its last cycle.
                    if (!on) begin
                        state_nxt = ST_IDLE;
                    end else if (cnt_zero) begin
                        state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    state_nxt = ST_BUSY;
                end
                ST_BUSY: begin
                    // An in-flight generation always completes; on is only
                    // consulted once the result is in hand.
                    if (dp_done) begin
                        if (stop_cond) begin
                            state_nxt = ST_HALT;
                        end else if (on) begin
                            state_nxt = ST_WAIT;
                            cnt_load  = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    if (step && !on) begin
                        state_nxt = ST_REQ;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        dp_start = 1'b0;
        busy     = 1'b0;
        stable   = 1'b0;
        case (state)
            ST_REQ: begin
                dp_start = 1'b1;
                busy     = 1'b1;
            end
            ST_BUSY: begin
                busy = 1'b1;
            end
            ST_HALT: begin
`ifdef LIFE_STABLE_DETECT_EN
                stable = 1'b1;
`else
                stable = 1'b0;
`endif
            end
            default: begin
                dp_start = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Grid register and generation counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_grid  <= '0;
            gen_count <= '0;
        end else if (load) begin
            cur_grid  <= seed;
            gen_count <= '0;
        end else if (commit) begin
            cur_grid  <= dp_grid;
            gen_count <= sat_inc(gen_count);
        end
    end

    assign display = cur_grid;

endmodule

// File: tb/tb_life_controller.sv
// ---------------------------------------------------------------------------
// tb_life_controller
//   Self-checking bench for life_controller (GEN_PERIOD = 4).
//   A behavioural datapath answers each dp_start three cycles later with the
//   Life rule applied to the grid it was handed (dead border). Stimulus
//   tasks push the expected (cycle, operand, gen_count) of every dp_start
//   into a scoreboard queue; an independent monitor pops and compares each
//   time the DUT raises dp_start. Scenario end states are checked directly.
// ---------------------------------------------------------------------------
module tb_life_controller;

    localparam int GP = 4;
    localparam logic [63:0] BLINKER_H = 64'h0000_0000_001C_0000;
    localparam logic [63:0] BLINKER_V = 64'h0000_0000_0808_0800;
    localparam logic [63:0] BLOCK     = 64'h0000_0000_0000_0303;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        on = 1'b0;
    logic        step = 1'b0;
    logic        load = 1'b0;
    logic [63:0] seed = '0;
    logic        dp_done = 1'b0;
    logic [63:0] dp_grid = '0;
    logic        dp_start;
    logic [63:0] cur_grid;
    logic [63:0] display;
    logic [15:0] gen_count;
    logic        stable;
    logic        busy;

    life_controller #(
        .GEN_PERIOD (GP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .on        (on),
        .step      (step),
        .load      (load),
        .seed      (seed),
        .dp_start  (dp_start),
        .cur_grid  (cur_grid),
        .dp_done   (dp_done),
        .dp_grid   (dp_grid),
        .display   (display),
        .gen_count (gen_count),
        .stable    (stable),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          cyc;
        logic [63:0] grid;
        logic [15:0] gen;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference Life rule: bit row*8+col, cells beyond the edge are dead.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] r;
        r = '0;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = row + dr;
                        cc = col + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            if (g[rr*8+cc]) n++;
                    end
                end
                r[row*8+col] = (n == 3) || (g[row*8+col] && n == 2);
            end
        end
        return r;
    endfunction

    // Behavioural datapath: answers three cycles after dp_start, drives
    // junk on dp_grid whenever dp_done is low.
    initial begin
        int          cd;
        logic [63:0] op;
        cd = 0;
        op = '0;
        forever begin
            @(posedge clk);
            #1;
            dp_done = 1'b0;
            dp_grid = {$urandom, $urandom};
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dp_done = 1'b1;
                    dp_grid = life_next(op);
                end
            end
            if (dp_start) begin
                cd = 3;
                op = cur_grid;
            end
        end
    end

    // Monitor: every dp_start must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && dp_start) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_dp_start: cycle %0d operand 0x%h, none expected", cyc, cur_grid);
                end else begin
                    e = sb_q.pop_front();
                    check("dp_start_cycle", 64'(cyc), 64'(e.cyc));
                    check("dp_operand", cur_grid, e.grid);
                    check("dp_gen_count", 64'(gen_count), 64'(e.gen));
                    check("busy_with_dp_start", 64'(busy), 64'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_start(input int c, input logic [63:0] g, input int gen);
        exp_t e;
        e.cyc  = c;
        e.grid = g;
        e.gen  = 16'(gen);
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name);
        check(name, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Free-run ngen generations from seed s, then drop on in the first WAIT
    // cycle after the last commit (or leave HALT in place if it stopped).
    task automatic run_free(input logic [63:0] s, input int ngen, input string tag);
        logic [63:0] g;
        logic [63:0] g_nxt;
        int          n;
        int          h;
        bit          halted;
        do_load(s);
        check({tag, "_load_grid"}, cur_grid, s);
        check({tag, "_load_gen"}, 64'(gen_count), 64'd0);
        on = 1'b1;
        n = cyc;
        g = s;
        h = 0;
        halted = 1'b0;
        for (int i = 0; i < ngen; i++) begin
            if (!halted) begin
                expect_start(n + GP + 1 + i * (GP + 4), g, i);
                g_nxt = life_next(g);
`ifdef LIFE_STABLE_DETECT_EN
                if (g_nxt == g || g_nxt == '0) halted = 1'b1;
`endif
                g = g_nxt;
                h = i + 1;
            end
        end
        ticks(GP + 1 + (ngen - 1) * (GP + 4) + 4);
        on = 1'b0;
        ticks(2);
        check({tag, "_grid"}, cur_grid, g);
        check({tag, "_display"}, display, g);
        check({tag, "_gen"}, 64'(gen_count), 64'(h));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_stable"}, 64'(stable), 64'(halted));
        drain({tag, "_sb_drained"});
    endtask

    initial begin
        int n;
        logic [63:0] s2;

        // Reset values
        reset_n = 1'b0;
        ticks(2);
        check("rst_cur_grid", cur_grid, 64'd0);
        check("rst_display", display, 64'd0);
        check("rst_gen_count", 64'(gen_count), 64'd0);
        check("rst_dp_start", 64'(dp_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stable", 64'(stable), 64'd0);
        reset_n = 1'b1;
        tick();

        // Blinker free-run: two generations, back to the horizontal phase
        run_free(BLINKER_H, 2, "blinker_run");

        // Single step from IDLE; a second step during BUSY is ignored
        do_load(BLINKER_H);
        n = cyc;
        step = 1'b1;
        expect_start(n + 1, BLINKER_H, 0);
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        ticks(6);
        check("step_grid", cur_grid, BLINKER_V);
        check("step_gen", 64'(gen_count), 64'd1);
        check("step_busy", 64'(busy), 64'd0);
        drain("step_sb_drained");

        // on dropped in the cycle after dp_start: commit, then IDLE
        do_load(BLINKER_H);
        on = 1'b1;
        n = cyc;
        expect_start(n + GP + 1, BLINKER_H, 0);
        ticks(GP + 2);
        on = 1'b0;
        ticks(6);
        check("offbusy_grid", cur_grid, BLINKER_V);
        check("offbusy_gen", 64'(gen_count), 64'd1);
        check("offbusy_busy", 64'(busy), 64'd0);
        drain("offbusy_sb_drained");

        // load during BUSY; the result arriving two cycles later is dropped
        do_load(BLINKER_H);
        on = 1'b1;
        n = cyc;
        expect_start(n + GP + 1, BLINKER_H, 0);
        ticks(GP + 2);
        s2 = {$urandom, $urandom};
        seed = s2;
        load = 1'b1;
        on = 1'b0;
        tick();
        load = 1'b0;
        ticks(4);
        check("loadbusy_grid", cur_grid, s2);
        check("loadbusy_gen", 64'(gen_count), 64'd0);
        check("loadbusy_busy", 64'(busy), 64'd0);
        drain("loadbusy_sb_drained");

        // Asynchronous reset mid-BUSY; stray dp_done after release ignored
        do_load(BLINKER_H);
        on = 1'b1;
        n = cyc;
        expect_start(n + GP + 1, BLINKER_H, 0);
        ticks(GP + 2);
        on = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_cur_grid", cur_grid, 64'd0);
        check("arst_gen_count", 64'(gen_count), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_dp_start", 64'(dp_start), 64'd0);
        check("arst_stable", 64'(stable), 64'd0);
        tick();
        reset_n = 1'b1;
        ticks(4);
        check("arst_after_grid", cur_grid, 64'd0);
        check("arst_after_gen", 64'(gen_count), 64'd0);
        check("arst_after_busy", 64'(busy), 64'd0);
        drain("arst_sb_drained");

        // Still life: halts after gen1 with detection, keeps running without
        run_free(BLOCK, 3, "block_run");
`ifdef LIFE_STABLE_DETECT_EN
        // Step out of HALT runs one more generation and halts again
        n = cyc;
        step = 1'b1;
        expect_start(n + 1, BLOCK, 1);
        tick();
        step = 1'b0;
        ticks(6);
        check("halt_step_grid", cur_grid, BLOCK);
        check("halt_step_gen", 64'(gen_count), 64'd2);
        check("halt_step_stable", 64'(stable), 64'd1);
        drain("halt_step_sb_drained");
`endif

        // Randomized seeds against the reference model
        for (int k = 0; k < 5; k++) begin
            logic [63:0] rs;
            rs = {$urandom, $urandom} & {$urandom, $urandom};
            run_free(rs, 3 + int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
